// File: rtl/bldc_motor_emulator_if.sv
// rtl/bldc_motor_emulator_if.sv - gate-side drive inputs and Hall/fault feedback between BLDC driver and motor emulator
interface bldc_motor_emulator_if #(
  parameter int counter_width = 32
);
  logic [5:0]               phase_enable;
  logic                     pwm_in;
  logic                     gate_enable;
  logic [counter_width-1:0] step_period;
  logic                     inject_hall_error;
  logic                     fault_clear;
  logic [2:0]               hall_values;
  logic                     fault_n;
  logic                     overcurrent_n;
  logic [2:0]               rotor_sector;
  logic [counter_width-1:0] step_count;

  modport master (
    output phase_enable, pwm_in, gate_enable, step_period, inject_hall_error, fault_clear,
    input  hall_values, fault_n, overcurrent_n, rotor_sector, step_count
  );

  modport slave (
    input  phase_enable, pwm_in, gate_enable, step_period, inject_hall_error, fault_clear,
    output hall_values, fault_n, overcurrent_n, rotor_sector, step_count
  );
endinterface

// File: rtl/bldc_motor_emulator.sv
// rtl/bldc_motor_emulator.sv - closed-loop BLDC rotor and Hall sensor model driven by gate-side outputs
module bldc_motor_emulator #(
  parameter int counter_width  = 32,
  parameter int stall_ticks    = 54_000,
  parameter int sync_stages    = 2,
  parameter int initial_sector = 0
) (
  input logic                 sys_clk,
  input logic                 reset_n,
  bldc_motor_emulator_if.slave bus
);
  localparam logic [2:0]               INIT_SECTOR = 3'(initial_sector);
  localparam logic [counter_width-1:0] STALL_MAX   = counter_width'(stall_ticks);

  function automatic logic [2:0] hall_of(input logic [2:0] s);
    case (s)
      3'd0:    hall_of = 3'b001;
      3'd1:    hall_of = 3'b011;
      3'd2:    hall_of = 3'b010;
      3'd3:    hall_of = 3'b110;
      3'd4:    hall_of = 3'b100;
      3'd5:    hall_of = 3'b101;
      default: hall_of = 3'b000;
    endcase
  endfunction

  logic [sync_stages-1:0]   r_pwm_sync;
  logic [2:0]               r_sector;
  logic [2:0]               r_hall;
  logic                     r_fault_n;
  logic                     r_oc_n;
  logic [counter_width-1:0] r_step_timer;
  logic [counter_width-1:0] r_stall_timer;
  logic [counter_width-1:0] r_step_count;

  logic [sync_stages:0]     w_pwm_chain;
  logic [2:0]               w_high;
  logic [2:0]               w_low;
  logic [2:0]               w_d;
  logic                     w_valid;
  logic                     w_on;
  logic                     w_shoot;
  logic                     w_aligned;
  logic [3:0]               w_diff;
  logic                     w_fwd;
  logic                     w_step;
  logic [counter_width-1:0] w_period_m1;
  logic [counter_width-1:0] w_stall_next;

  assign w_pwm_chain = {r_pwm_sync, bus.pwm_in};
  assign w_high      = bus.phase_enable[5:3];
  assign w_low       = bus.phase_enable[2:0];

  // Only the six single-high/single-low pairs on different phases produce torque.
  always_comb begin
    w_valid = 1'b1;
    w_d     = 3'd0;
    case ({w_high, w_low})
      6'b100_010: w_d = 3'd0;
      6'b100_001: w_d = 3'd1;
      6'b010_001: w_d = 3'd2;
      6'b010_100: w_d = 3'd3;
      6'b001_100: w_d = 3'd4;
      6'b001_010: w_d = 3'd5;
      default:    w_valid = 1'b0;
    endcase
  end

  assign w_on      = bus.gate_enable & w_valid & w_pwm_chain[sync_stages];
  assign w_shoot   = bus.gate_enable & (|(w_high & w_low));
  assign w_aligned = w_valid & (w_d == r_sector);

  // (d - s) mod 6; a distance of 3 is a tie and resolves forward.
  assign w_diff = (w_d >= r_sector) ? (4'(w_d) - 4'(r_sector))
                                    : (4'(w_d) + 4'd6 - 4'(r_sector));
  assign w_fwd  = (w_diff <= 4'd3);

  assign w_period_m1 = (bus.step_period == '0) ? '0 : bus.step_period - 1'b1;
  assign w_step      = r_fault_n & w_on & ~w_aligned & (r_step_timer >= w_period_m1);

  always_comb begin
    w_stall_next = '0;
    if (r_fault_n && w_on && w_aligned) begin
      w_stall_next = (r_stall_timer == STALL_MAX) ? r_stall_timer : r_stall_timer + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_sync    <= '0;
      r_sector      <= INIT_SECTOR;
      r_hall        <= hall_of(INIT_SECTOR);
      r_fault_n     <= 1'b1;
      r_oc_n        <= 1'b1;
      r_step_timer  <= '0;
      r_stall_timer <= '0;
      r_step_count  <= '0;
    end else begin
      r_pwm_sync    <= w_pwm_chain[sync_stages-1:0];
      r_hall        <= bus.inject_hall_error ? 3'b000 : hall_of(r_sector);
      r_stall_timer <= w_stall_next;
      r_oc_n        <= (w_stall_next != STALL_MAX);
      if (!r_fault_n) begin
        r_step_timer <= '0;
        if (bus.fault_clear && !w_shoot) begin
          r_fault_n <= 1'b1;
        end
      end else begin
        if (w_shoot) begin
          r_fault_n <= 1'b0;
        end
        if (!w_valid || w_aligned) begin
          r_step_timer <= '0;
        end else if (w_step) begin
          r_step_timer <= '0;
          if (w_fwd) begin
            r_sector     <= (r_sector == 3'd5) ? 3'd0 : r_sector + 3'd1;
            r_step_count <= r_step_count + 1'b1;
          end else begin
            r_sector     <= (r_sector == 3'd0) ? 3'd5 : r_sector - 3'd1;
            r_step_count <= r_step_count - 1'b1;
          end
        end else if (w_on) begin
          r_step_timer <= r_step_timer + 1'b1;
        end
      end
    end
  end

  assign bus.hall_values   = r_hall;
  assign bus.fault_n       = r_fault_n;
  assign bus.overcurrent_n = r_oc_n;
  assign bus.rotor_sector  = r_sector;
  assign bus.step_count    = r_step_count;
endmodule

// File: tb/tb_bldc_motor_emulator.sv
// tb/tb_bldc_motor_emulator.sv - self-checking bench for bldc_motor_emulator
module tb_bldc_motor_emulator;
  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;

  bldc_motor_emulator_if #(.counter_width(32)) bus();

  bldc_motor_emulator #(
    .counter_width(32),
    .stall_ticks(100),
    .sync_stages(2),
    .initial_sector(2)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [5:0] pe;
    logic       gate;
    logic       pwm;
    int         period;
    int         cycles;
    int         exp_sector;
    int         exp_count;
    logic       exp_fault_n;
  } vec_t;

  typedef struct {
    int   sector;
    int   count;
    logic fault_n;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   errors = 0;
  int   checks = 0;
  int   s_m = 2;
  int   c_m = 0;

  function automatic logic [2:0] hall_tab(input int s);
    case (s)
      0: hall_tab = 3'b001;
      1: hall_tab = 3'b011;
      2: hall_tab = 3'b010;
      3: hall_tab = 3'b110;
      4: hall_tab = 3'b100;
      5: hall_tab = 3'b101;
      default: hall_tab = 3'b111;
    endcase
  endfunction

  function automatic logic [5:0] drive_pat(input int d);
    case (d)
      0: drive_pat = 6'b100_010;
      1: drive_pat = 6'b100_001;
      2: drive_pat = 6'b010_001;
      3: drive_pat = 6'b010_100;
      4: drive_pat = 6'b001_100;
      5: drive_pat = 6'b001_010;
      default: drive_pat = 6'b000_000;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    s_m = 2;
    c_m = 0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    exp_t e;
    do_reset();
    bus.gate_enable  = v.gate;
    bus.pwm_in       = v.pwm;
    bus.step_period  = 32'(v.period);
    bus.phase_enable = 6'b0;
    repeat (3) @(negedge sys_clk);
    e.sector  = v.exp_sector;
    e.count   = v.exp_count;
    e.fault_n = v.exp_fault_n;
    sb.push_back(e);
    bus.phase_enable = v.pe;
    repeat (v.cycles) @(negedge sys_clk);
    e = sb.pop_front();
    check($sformatf("vec%0d sector", idx), longint'(bus.rotor_sector), longint'(e.sector));
    check($sformatf("vec%0d count", idx), longint'($signed(bus.step_count)), longint'(e.count));
    check($sformatf("vec%0d fault_n", idx), longint'(bus.fault_n), longint'(e.fault_n));
  endtask

  task automatic run_steps(input int dir, input int n, input bit toggle, input int gap);
    exp_t e;
    int   cyc;
    int   last;
    int   tgt;
    bit   got;
    bit   hall_due;
    cyc = 0;
    last = 0;
    hall_due = 1'b0;
    for (int i = 0; i < n; i++) begin
      tgt = (dir > 0) ? (s_m + 1) % 6 : (s_m + 5) % 6;
      bus.phase_enable = drive_pat(tgt);
      e.sector  = tgt;
      e.count   = c_m + dir;
      e.fault_n = 1'b1;
      sb.push_back(e);
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge sys_clk);
        cyc++;
        if (toggle) bus.pwm_in = ~bus.pwm_in;
        if (hall_due) begin
          check("step hall", longint'(bus.hall_values), longint'(hall_tab(s_m)));
          hall_due = 1'b0;
        end
        if (int'(bus.rotor_sector) != s_m) got = 1'b1;
      end
      e = sb.pop_front();
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL step timeout: sector stayed %0d expected %0d", bus.rotor_sector, e.sector);
      end
      check("step sector", longint'(bus.rotor_sector), longint'(e.sector));
      check("step count", longint'($signed(bus.step_count)), longint'(e.count));
      if (i > 0) check("step gap", longint'(cyc - last), longint'(gap));
      last = cyc;
      s_m = e.sector;
      c_m = e.count;
      hall_due = 1'b1;
    end
    @(negedge sys_clk);
    if (toggle) bus.pwm_in = ~bus.pwm_in;
    check("step hall", longint'(bus.hall_values), longint'(hall_tab(s_m)));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bus.phase_enable      = 6'b0;
    bus.pwm_in            = 1'b0;
    bus.gate_enable       = 1'b0;
    bus.step_period       = 32'd10;
    bus.inject_hall_error = 1'b0;
    bus.fault_clear       = 1'b0;

    vecs[0]  = '{6'b100_010, 1'b1, 1'b1, 10, 10, 1, -1, 1'b1};
    vecs[1]  = '{6'b100_001, 1'b1, 1'b1, 10, 10, 1, -1, 1'b1};
    vecs[2]  = '{6'b010_001, 1'b1, 1'b1, 10, 10, 2,  0, 1'b1};
    vecs[3]  = '{6'b010_100, 1'b1, 1'b1, 10,  9, 2,  0, 1'b1};
    vecs[4]  = '{6'b010_100, 1'b1, 1'b1, 10, 10, 3,  1, 1'b1};
    vecs[5]  = '{6'b001_100, 1'b1, 1'b1, 10, 10, 3,  1, 1'b1};
    vecs[6]  = '{6'b001_010, 1'b1, 1'b1, 10, 10, 3,  1, 1'b1};
    vecs[7]  = '{6'b110_001, 1'b1, 1'b1, 10, 10, 2,  0, 1'b1};
    vecs[8]  = '{6'b100_100, 1'b1, 1'b1, 10, 10, 2,  0, 1'b0};
    vecs[9]  = '{6'b100_100, 1'b0, 1'b1, 10, 10, 2,  0, 1'b1};
    vecs[10] = '{6'b010_100, 1'b0, 1'b1, 10, 20, 2,  0, 1'b1};
    vecs[11] = '{6'b010_100, 1'b1, 1'b0, 10, 20, 2,  0, 1'b1};
    vecs[12] = '{6'b001_010, 1'b1, 1'b1,  0,  3, 5,  3, 1'b1};
    vecs[13] = '{6'b000_000, 1'b1, 1'b1, 10, 10, 2,  0, 1'b1};

    // Reset state
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    @(negedge sys_clk);
    check("reset sector", longint'(bus.rotor_sector), 2);
    check("reset hall", longint'(bus.hall_values), longint'(3'b010));
    check("reset fault_n", longint'(bus.fault_n), 1);
    check("reset overcurrent_n", longint'(bus.overcurrent_n), 1);
    check("reset count", longint'($signed(bus.step_count)), 0);

    for (int i = 0; i < 14; i++) apply_vec(vecs[i], i);

    // Forward spin, full-duty PWM
    do_reset();
    bus.gate_enable  = 1'b1;
    bus.pwm_in       = 1'b1;
    bus.step_period  = 32'd10;
    bus.phase_enable = 6'b0;
    repeat (3) @(negedge sys_clk);
    run_steps(1, 12, 1'b0, 10);
    check("fwd total count", longint'($signed(bus.step_count)), 12);

    // Asynchronous reset mid-operation
    @(negedge sys_clk);
    reset_n = 1'b0;
    #1;
    check("async reset count", longint'($signed(bus.step_count)), 0);
    check("async reset hall", longint'(bus.hall_values), longint'(3'b010));
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    s_m = 2;
    c_m = 0;

    // Reverse spin at 50% duty
    bus.phase_enable = 6'b0;
    repeat (3) @(negedge sys_clk);
    run_steps(-1, 6, 1'b1, 20);
    check("rev total count", longint'($signed(bus.step_count)), -6);

    // Stall detection and release
    bus.pwm_in       = 1'b1;
    bus.phase_enable = 6'b0;
    repeat (3) @(negedge sys_clk);
    bus.phase_enable = drive_pat(s_m);
    repeat (99) @(negedge sys_clk);
    check("stall before limit", longint'(bus.overcurrent_n), 1);
    @(negedge sys_clk);
    check("stall at limit", longint'(bus.overcurrent_n), 0);
    repeat (20) @(negedge sys_clk);
    check("stall saturated", longint'(bus.overcurrent_n), 0);
    check("stall no motion", longint'(bus.rotor_sector), longint'(s_m));
    bus.phase_enable = drive_pat((s_m + 1) % 6);
    @(negedge sys_clk);
    check("stall release", longint'(bus.overcurrent_n), 1);
    bus.phase_enable = 6'b0;
    @(negedge sys_clk);

    // Shoot-through fault latch
    bus.phase_enable = 6'b100_100;
    @(negedge sys_clk);
    check("fault set", longint'(bus.fault_n), 0);
    bus.fault_clear = 1'b1;
    @(negedge sys_clk);
    bus.fault_clear = 1'b0;
    check("fault clear blocked", longint'(bus.fault_n), 0);
    bus.phase_enable = drive_pat((s_m + 1) % 6);
    repeat (30) @(negedge sys_clk);
    check("fault rotor frozen", longint'(bus.rotor_sector), longint'(s_m));
    check("fault still latched", longint'(bus.fault_n), 0);
    bus.fault_clear = 1'b1;
    @(negedge sys_clk);
    bus.fault_clear = 1'b0;
    check("fault cleared", longint'(bus.fault_n), 1);
    repeat (9) @(negedge sys_clk);
    check("post-fault timer fresh", longint'(bus.rotor_sector), longint'(s_m));
    @(negedge sys_clk);
    check("post-fault step", longint'(bus.rotor_sector), longint'((s_m + 1) % 6));
    bus.phase_enable = 6'b0;

    // Hall injection and tie-break forward from sector 0 with d=3
    do_reset();
    bus.gate_enable  = 1'b1;
    bus.pwm_in       = 1'b1;
    bus.step_period  = 32'd10;
    repeat (3) @(negedge sys_clk);
    run_steps(1, 4, 1'b0, 10);
    bus.inject_hall_error = 1'b1;
    bus.phase_enable      = drive_pat(3);
    @(negedge sys_clk);
    check("inject hall", longint'(bus.hall_values), 0);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge sys_clk);
      if (bus.rotor_sector != 3'd0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL tie step timeout: sector %0d expected 1", bus.rotor_sector);
    end
    check("tie sector", longint'(bus.rotor_sector), 1);
    check("tie count", longint'($signed(bus.step_count)), 5);
    check("inject hall held", longint'(bus.hall_values), 0);
    bus.inject_hall_error = 1'b0;
    @(negedge sys_clk);
    check("inject release hall", longint'(bus.hall_values), longint'(3'b011));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
